// File: rtl/weight_fifo_pkg.sv
// Shared defaults, width helpers and output-stage state encoding for the
// weight tile FIFO.
package weight_fifo_pkg;

  localparam int DEF_WEIGHT_BW   = 8;
  localparam int DEF_NUM_PE_ROWS = 8;
  localparam int DEF_MATRIX_SIZE = 8;
  localparam int DEF_FIFO_DEPTH  = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } ser_state_e;

  // Width of one PE row of weights.
  function automatic int calc_row_w(input int weight_bw, input int matrix_size);
    return weight_bw * matrix_size;
  endfunction

  // Width of a full tile (all PE rows).
  function automatic int calc_dw(input int weight_bw, input int matrix_size,
                                 input int num_rows);
    return calc_row_w(weight_bw, matrix_size) * num_rows;
  endfunction

endpackage

// File: rtl/wfifo_row_serializer.sv
// Output stage: holds one tile and presents it either as a single beat or
// row by row, requesting the next tile from storage on the final handshake.
module wfifo_row_serializer
  import weight_fifo_pkg::*;
#(
  parameter  int ROW_W       = 64,
  parameter  int NUM_PE_ROWS = 8,
  localparam int DW          = ROW_W * NUM_PE_ROWS,
  localparam int RIW         = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             tile_avail,
  input  logic [DW-1:0]    tile_in,
  input  logic             row_mode,
  input  logic             out_ready,
  output logic             pop,
  output logic             out_valid,
  output logic [DW-1:0]    out_tile,
  output logic [ROW_W-1:0] out_row,
  output logic [RIW-1:0]   row_idx,
  output logic             out_last
);

  localparam logic [RIW-1:0] LAST_ROW = RIW'(NUM_PE_ROWS - 1);

  ser_state_e state;
  logic       mode_q;
  logic       fire;

  assign out_valid = (state == ST_HOLD);
  assign fire      = out_valid && out_ready;
  // Whole-tile mode ends on the first beat; row mode ends on the last row.
  assign out_last  = out_valid && (!mode_q || (row_idx == LAST_ROW));
  // Load from IDLE, or chain the next tile on the final handshake so a
  // continuously ready consumer sees no bubble between tiles.
  assign pop       = !flush && tile_avail &&
                     ((state == ST_IDLE) || (fire && out_last));
  assign out_row   = out_tile[int'(row_idx) * ROW_W +: ROW_W];

  // Hold register, latched mode and row counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= 1'b0;
      row_idx  <= '0;
      out_tile <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      row_idx  <= '0;
    end else if (pop) begin
      state    <= ST_HOLD;
      out_tile <= tile_in;
      mode_q   <= row_mode;
      row_idx  <= '0;
    end else if (fire) begin
      if (out_last) begin
        state   <= ST_IDLE;
        row_idx <= '0;
      end else begin
        row_idx <= row_idx + RIW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_tile_fifo.sv
// Tile FIFO feeding a PE array: circular storage of whole weight tiles with
// occupancy flags, plus a serializer that streams the head tile.
module weight_tile_fifo
  import weight_fifo_pkg::*;
#(
  parameter  int WEIGHT_BW   = DEF_WEIGHT_BW,
  parameter  int NUM_PE_ROWS = DEF_NUM_PE_ROWS,
  parameter  int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int AF_LEVEL    = FIFO_DEPTH - 1,
  localparam int ROW_W       = calc_row_w(WEIGHT_BW, MATRIX_SIZE),
  localparam int DW          = calc_dw(WEIGHT_BW, MATRIX_SIZE, NUM_PE_ROWS),
  localparam int CW          = $clog2(FIFO_DEPTH + 1),
  localparam int RIW         = (NUM_PE_ROWS > 1) ? $clog2(NUM_PE_ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             write_enable,
  input  logic [DW-1:0]    data_in,
  input  logic             row_mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_tile,
  output logic [ROW_W-1:0] out_row,
  output logic [RIW-1:0]   row_idx,
  output logic             out_last,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AF_LEVEL));
  // A pop in the same cycle does not make room for a push into a full FIFO.
  assign push        = write_enable && !full && !flush;

  // Tile storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (write_enable && full) overflow <= 1'b1;
    end
  end

  wfifo_row_serializer #(
    .ROW_W      (ROW_W),
    .NUM_PE_ROWS(NUM_PE_ROWS)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .tile_avail(!empty),
    .tile_in   (mem[rd_ptr]),
    .row_mode  (row_mode),
    .out_ready (out_ready),
    .pop       (pop),
    .out_valid (out_valid),
    .out_tile  (out_tile),
    .out_row   (out_row),
    .row_idx   (row_idx),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Directed bench for weight_tile_fifo: a depth-4 instance checked through
// every phase and a depth-8 instance sharing its inputs for the wrap run.
module tb_weight_tile_fifo;

  localparam int WBW   = 8;
  localparam int ROWS  = 8;
  localparam int MS    = 8;
  localparam int ROW_W = WBW * MS;
  localparam int DW    = ROW_W * ROWS;

  logic clk = 1'b0;
  logic rst, flush, write_enable, row_mode, out_ready;
  logic [DW-1:0] data_in;

  logic             out_valid, out_last, full, empty, almost_full, overflow;
  logic [DW-1:0]    out_tile;
  logic [ROW_W-1:0] out_row;
  logic [2:0]       row_idx;
  logic [2:0]       count;

  logic             out_valid_d8, out_last_d8, full_d8, empty_d8, almost_full_d8, overflow_d8;
  logic [DW-1:0]    out_tile_d8;
  logic [ROW_W-1:0] out_row_d8;
  logic [2:0]       row_idx_d8;
  logic [3:0]       count_d8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_tile_fifo dut (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(write_enable),
    .data_in(data_in), .row_mode(row_mode), .out_ready(out_ready),
    .out_valid(out_valid), .out_tile(out_tile), .out_row(out_row),
    .row_idx(row_idx), .out_last(out_last), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow)
  );

  weight_tile_fifo #(.FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(write_enable),
    .data_in(data_in), .row_mode(row_mode), .out_ready(out_ready),
    .out_valid(out_valid_d8), .out_tile(out_tile_d8), .out_row(out_row_d8),
    .row_idx(row_idx_d8), .out_last(out_last_d8), .full(full_d8), .empty(empty_d8),
    .almost_full(almost_full_d8), .count(count_d8), .overflow(overflow_d8)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk_tile(input int k);
    logic [DW-1:0] t;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < MS; c++)
        t[(r*MS + c)*WBW +: WBW] = 8'(k*37 + r*8 + c);
    return t;
  endfunction

  function automatic logic [ROW_W-1:0] mk_row(input int k, input int r);
    logic [DW-1:0] t;
    t = mk_tile(k);
    return t[r*ROW_W +: ROW_W];
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n4, n8;
    rst = 1'b1; flush = 1'b0; write_enable = 1'b0; row_mode = 1'b0;
    out_ready = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state of both instances
    check_val("rst_valid", out_valid, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_af", almost_full, 0);
    check_val("rst_count", count, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_row_idx", row_idx, 0);
    check_val("rst_tile", out_tile, 0);
    check_val("rst_row", out_row, 0);
    check_val("rst8_valid", out_valid_d8, 0);
    check_val("rst8_empty", empty_d8, 1);
    check_val("rst8_full", full_d8, 0);
    check_val("rst8_af", almost_full_d8, 0);
    check_val("rst8_count", count_d8, 0);
    check_val("rst8_ovf", overflow_d8, 0);
    check_val("rst8_last", out_last_d8, 0);
    check_val("rst8_row_idx", row_idx_d8, 0);
    check_val("rst8_tile", out_tile_d8, 0);
    check_val("rst8_row", out_row_d8, 0);

    // four pushes with consumer stalled: T0 goes to hold, three stay queued
    for (int k = 0; k < 4; k++) begin
      write_enable = 1'b1; data_in = mk_tile(k); tick();
    end
    write_enable = 1'b0;
    check_val("fill_count3", count, 3);
    check_val("fill_full0", full, 0);
    check_val("fill_af3", almost_full, 1);
    check_val("fill_valid", out_valid, 1);
    check_val("fill_tile_t0", out_tile, mk_tile(0));
    check_val("fill_last_mode0", out_last, 1);

    write_enable = 1'b1; data_in = mk_tile(4); tick();
    write_enable = 1'b0;
    check_val("fill_count4", count, 4);
    check_val("fill_full1", full, 1);
    check_val("fill_af4", almost_full, 1);
    check_val("fill_ovf_before", overflow, 0);

    // push into full storage is dropped and flags overflow
    write_enable = 1'b1; data_in = mk_tile(5); tick();
    write_enable = 1'b0;
    check_val("ovf_set", overflow, 1);
    check_val("ovf_count", count, 4);

    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      if (out_valid) begin
        check_val("drain_tile", out_tile, mk_tile(n));
        n++;
      end
      tick();
    end
    check_val("drain_n", n, 5);
    check_val("drain_valid0", out_valid, 0);
    check_val("drain_empty", empty, 1);
    check_val("ovf_sticky", overflow, 1);
    out_ready = 1'b0;

    flush = 1'b1; tick(); flush = 1'b0;
    check_val("flush_ovf_clr", overflow, 0);
    check_val("flush_count", count, 0);

    // row streaming; mode input changes after the tile is latched
    row_mode = 1'b1; out_ready = 1'b1;
    write_enable = 1'b1; data_in = mk_tile(6); tick();
    write_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      tick();
    end
    check_val("row_valid", out_valid, 1);
    row_mode = 1'b0;
    for (int r = 0; r < 8; r++) begin
      check_val("row_idx", row_idx, r);
      check_val("row_data", out_row, mk_row(6, r));
      check_val("row_last", out_last, (r == 7) ? 1 : 0);
      check_val("row_valid_held", out_valid, 1);
      tick();
    end
    check_val("row_done", out_valid, 0);

    // whole-tile beats back to back
    out_ready = 1'b0; row_mode = 1'b0;
    for (int k = 7; k < 10; k++) begin
      write_enable = 1'b1; data_in = mk_tile(k); tick();
    end
    write_enable = 1'b0;
    check_val("burst_count", count, 2);
    check_val("burst_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      check_val("burst_beat_valid", out_valid, 1);
      check_val("burst_beat_last", out_last, 1);
      check_val("burst_beat_tile", out_tile, mk_tile(7 + j));
      tick();
    end
    check_val("burst_done", out_valid, 0);

    // flush mid-stream with concurrent write
    row_mode = 1'b1; out_ready = 1'b1;
    for (int k = 10; k < 12; k++) begin
      write_enable = 1'b1; data_in = mk_tile(k); tick();
    end
    write_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (row_idx == 3'd3) break;
      tick();
    end
    check_val("mid_row3", row_idx, 3);
    check_val("mid_tile", out_tile, mk_tile(10));
    check_val("mid_count", count, 1);
    flush = 1'b1; write_enable = 1'b1; data_in = mk_tile(12); tick();
    flush = 1'b0; write_enable = 1'b0;
    check_val("fl_valid", out_valid, 0);
    check_val("fl_count", count, 0);
    check_val("fl_empty", empty, 1);
    check_val("fl_ovf", overflow, 0);
    check_val("fl_row_idx", row_idx, 0);
    tick();
    check_val("fl_write_dropped", empty, 1);
    check_val("fl_still_idle", out_valid, 0);

    // asynchronous reset between edges while holding
    row_mode = 1'b0; out_ready = 1'b0;
    for (int k = 13; k < 15; k++) begin
      write_enable = 1'b1; data_in = mk_tile(k); tick();
    end
    write_enable = 1'b0;
    check_val("ar_pre_valid", out_valid, 1);
    check_val("ar_pre_count", count, 1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_valid", out_valid, 0);
    check_val("ar_tile", out_tile, 0);
    check_val("ar_last", out_last, 0);
    check_val("ar_count", count, 0);
    check_val("ar_empty", empty, 1);
    check_val("ar_row_idx", row_idx, 0);
    check_val("ar8_valid", out_valid_d8, 0);
    #2 rst = 1'b0;
    tick();
    check_val("ar_post_empty", empty, 1);

    // continuous stream: pointers wrap several times on both depths
    row_mode = 1'b0; out_ready = 1'b1;
    n4 = 0; n8 = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        check_val("wrap4_tile", out_tile, mk_tile(20 + n4));
        n4++;
      end
      if (out_valid_d8) begin
        check_val("wrap8_tile", out_tile_d8, mk_tile(20 + n8));
        n8++;
      end
      if (i < 20) begin
        write_enable = 1'b1; data_in = mk_tile(20 + i);
      end else begin
        write_enable = 1'b0;
      end
      tick();
    end
    check_val("wrap4_n", n4, 20);
    check_val("wrap8_n", n8, 20);
    check_val("wrap8_empty", empty_d8, 1);
    check_val("wrap8_ovf", overflow_d8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_tile_fifo.md
WEIGHT_TILE_FIFO -- requirements
Module: weight_tile_fifo

Interface
REQ-001 SHALL have parameter WEIGHT_BW, default 8, bits per weight.
REQ-002 SHALL have parameter NUM_PE_ROWS, default 8, rows per tile.
REQ-003 SHALL have parameter MATRIX_SIZE, default 8, weights per row.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, tile entries; power of two, >=2.
REQ-005 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, almost_full threshold.
REQ-006 SHALL derive ROW_W=WEIGHT_BW*MATRIX_SIZE, DW=ROW_W*NUM_PE_ROWS, CW=$clog2(FIFO_DEPTH+1).
REQ-007 SHALL have one clock; reset asynchronous, active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 flush  in  1  synchronous clear of storage and output stage.
REQ-011 write_enable  in  1  push data_in this cycle.
REQ-012 data_in  in  DW  tile; row r at bits [(r+1)*ROW_W-1 : r*ROW_W].
REQ-013 row_mode  in  1  1=stream tile row by row, 0=whole tile in one beat.
REQ-014 out_ready  in  1  consumer accepts current beat.
REQ-015 out_valid  out  1  beat held on outputs.
REQ-016 out_tile  out  DW  held tile.
REQ-017 out_row  out  ROW_W  slice row_idx of held tile.
REQ-018 row_idx  out  $clog2(NUM_PE_ROWS)  current row index.
REQ-019 out_last  out  1  final beat of held tile.
REQ-020 full, empty, almost_full  out  1 each  storage status.
REQ-021 count  out  CW  tiles in storage (excludes held tile).
REQ-022 overflow  out  1  sticky: write attempted while full.

Function
REQ-023 Write accepted iff write_enable && !full && !flush; wr_ptr wraps modulo FIFO_DEPTH.
REQ-024 Write while full SHALL be dropped, storage unchanged, overflow set next cycle.
REQ-025 full=(count==FIFO_DEPTH); empty=(count==0); almost_full=(count>=AF_LEVEL); all registered-state functions.
REQ-026 Output FSM states IDLE, HOLD.
REQ-027 IDLE: if !empty, load mem[rd_ptr] into hold register, pop (rd_ptr++, count--), latch row_mode, row_idx=0, go HOLD.
REQ-028 HOLD: out_valid=1; out_tile, out_row, row_idx stable until out_valid&&out_ready.
REQ-029 out_last = latched mode 0, or row_idx==NUM_PE_ROWS-1.
REQ-030 Handshake on non-last beat: row_idx++.
REQ-031 Handshake on last beat: if !empty load next tile same edge (zero-bubble), else IDLE.
REQ-032 Same-cycle push and pop: count unchanged; push into full storage still dropped even if pop same cycle.
REQ-033 Latency: write in cycle N -> count/empty updated N+1 -> out_valid earliest N+2 when IDLE.
REQ-034 row_mode changes mid-tile SHALL not affect held tile.
REQ-035 flush: pointers, count, row_idx=0, FSM IDLE, out_valid=0, overflow=0 next edge; concurrent write dropped.
REQ-036 out_valid SHALL not drop without handshake except by flush or rst.

Reset
REQ-037 rst SHALL asynchronously force: pointers=0, count=0, FSM IDLE, out_valid=0, row_idx=0, overflow=0, hold register=0; hence empty=1, full=0, almost_full=0, out_last=0.
REQ-038 Storage array need not be reset.

Structure
REQ-039 Package weight_fifo_pkg SHALL hold default parameters, ROW_W/DW helper functions, FSM state enum.
REQ-040 Output FSM and row slicing SHALL be sub-module wfifo_row_serializer; storage and pointers in top.

Verification
REQ-041 Reset, push 4 tiles (T0..T3), out_ready=0 -> after T0 loaded, count=3, full=0, out_tile=T0; fifth push during hold -> count=4, full=1, almost_full=1.
REQ-042 Full with extra push -> dropped, overflow=1 next cycle, later outputs T0..T3 unchanged in order.
REQ-043 row_mode=1, out_ready=1, one tile -> 8 beats, row_idx 0..7, out_row = matching slice, out_last only at row_idx=7.
REQ-044 row_mode=0, 3 tiles queued, out_ready=1 -> 3 consecutive beats, out_last=1 each, no bubble between.
REQ-045 Mid-stream row 3, assert flush with write_enable -> next cycle out_valid=0, count=0, empty=1, overflow=0, write dropped.
REQ-046 Assert rst asynchronously mid-HOLD between clock edges -> outputs reach reset values before next edge; FIFO_DEPTH=8 rerun wraps pointers twice, data order preserved.
